// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, drives imem req/gnt/rvalid
// and feeds decode through an output register backed by a one-entry skid.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc2,
  output logic [31:0] instr2,
  output logic        instruction_addr_misaligned2,
  output logic        valid2
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_EXC
  } state_t;

  state_t state;
  state_t state_n;

  logic [31:0] fetch_pc;
  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        skid_valid;

  logic flush;
  logic aligned;
  logic out_free;
  logic req;
  logic ld_mem;
  logic ld_exc;
  logic ld_skid;
  logic cap_skid;

  assign flush    = trap | redirect;
  assign tgt      = trap ? trap_pc : redirect_pc;
  assign aligned  = (fetch_pc[1:0] == 2'b00);
  assign out_free = !valid2 || !stall;
  assign pc_plus4 = fetch_pc + 32'd4;

  // Gated so the request is low for as long as reset is held.
  assign imem_req = req & nrst;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: begin
        if (flush) begin
          state_n = S_FETCH;
        end else if (req && imem_gnt) begin
          state_n = S_WAIT;
        end else if (ld_exc) begin
          state_n = S_EXC;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_n = imem_rvalid ? S_FETCH : S_DRAIN;
        end else if (ld_mem) begin
          state_n = imem_gnt ? S_WAIT : S_FETCH;
        end else if (cap_skid) begin
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush || ld_skid) begin
          state_n = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_n = S_FETCH;
        end
      end
      S_EXC: begin
        if (flush) begin
          state_n = S_FETCH;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    imem_addr = fetch_pc;
    ld_mem    = 1'b0;
    ld_exc    = 1'b0;
    ld_skid   = 1'b0;
    cap_skid  = 1'b0;
    if (!flush) begin
      case (state)
        S_FETCH: begin
          if (aligned) begin
            req = 1'b1;
          end else if (out_free) begin
            ld_exc = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (out_free) begin
              ld_mem    = 1'b1;
              req       = 1'b1;
              imem_addr = pc_plus4;
            end else begin
              cap_skid = 1'b1;
            end
          end
        end
        S_HOLD: begin
          ld_skid = !stall;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fetch_pc <= RESET_PC;
    end else if (flush) begin
      fetch_pc <= tgt;
    end else if (ld_mem || ld_skid) begin
      fetch_pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc2                          <= 32'd0;
      instr2                       <= NOP_INSTR;
      instruction_addr_misaligned2 <= 1'b0;
      valid2                       <= 1'b0;
    end else if (flush) begin
      instr2                       <= NOP_INSTR;
      instruction_addr_misaligned2 <= 1'b0;
      valid2                       <= 1'b0;
    end else if (ld_mem) begin
      pc2                          <= fetch_pc;
      instr2                       <= imem_rdata;
      instruction_addr_misaligned2 <= 1'b0;
      valid2                       <= 1'b1;
    end else if (ld_exc) begin
      pc2                          <= fetch_pc;
      instr2                       <= NOP_INSTR;
      instruction_addr_misaligned2 <= 1'b1;
      valid2                       <= 1'b1;
    end else if (ld_skid) begin
      pc2                          <= skid_pc;
      instr2                       <= skid_valid ? skid_instr : NOP_INSTR;
      instruction_addr_misaligned2 <= 1'b0;
      valid2                       <= skid_valid;
    end else if (!stall) begin
      instr2                       <= NOP_INSTR;
      instruction_addr_misaligned2 <= 1'b0;
      valid2                       <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      skid_pc    <= 32'd0;
      skid_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
    end else if (flush || ld_skid) begin
      skid_valid <= 1'b0;
    end else if (cap_skid) begin
      skid_pc    <= fetch_pc;
      skid_instr <= imem_rdata;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: echo memory (instr == addr), stream model of the
// expected presented PCs, plus directed cycle-exact expectations.
module tb_fetch_stage;

  localparam logic [31:0] RST = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk;
  logic        nrst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [31:0] trap_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc2;
  logic [31:0] instr2;
  logic        mis2;
  logic        valid2;

  logic        gnt_en;
  logic        rv_block;
  logic        p_v = 1'b0;
  logic [31:0] p_addr = 32'd0;
  logic        armed = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage #(
    .RESET_PC (RST),
    .NOP_INSTR(NOP)
  ) dut (
    .clk                         (clk),
    .nrst                        (nrst),
    .stall                       (stall),
    .redirect                    (redirect),
    .redirect_pc                 (redirect_pc),
    .trap                        (trap),
    .trap_pc                     (trap_pc),
    .imem_req                    (imem_req),
    .imem_addr                   (imem_addr),
    .imem_gnt                    (imem_gnt),
    .imem_rvalid                 (imem_rvalid),
    .imem_rdata                  (imem_rdata),
    .pc2                         (pc2),
    .instr2                      (instr2),
    .instruction_addr_misaligned2(mis2),
    .valid2                      (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Echo memory: one response per grant, next cycle unless blocked.
  assign imem_gnt    = gnt_en;
  assign imem_rvalid = p_v && !rv_block;
  assign imem_rdata  = p_addr;

  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      p_v    <= 1'b1;
      p_addr <= imem_addr;
    end else if (imem_rvalid) begin
      p_v <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ne();
    @(negedge clk);
  endtask

  // Stream model: next PC decode should see, flush/hold/exception tracking.
  initial begin
    logic [31:0] exp_pc;
    logic [31:0] h_pc;
    logic [31:0] h_instr;
    logic        h_mis;
    bit          held;
    bit          flushed;
    bit          exc_wait;
    exp_pc   = RST;
    h_pc     = 0;
    h_instr  = 0;
    h_mis    = 0;
    held     = 0;
    flushed  = 0;
    exc_wait = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (!nrst) begin
          chk("m_rst_valid2", valid2, 0);
          chk("m_rst_instr2", instr2, NOP);
          exp_pc   = RST;
          held     = 0;
          flushed  = 0;
          exc_wait = 0;
        end else begin
          if (imem_req) chk("m_req_align", imem_addr[1:0], 0);
          if (flushed || exc_wait) begin
            chk("m_empty", valid2, 0);
          end else if (valid2 && held) begin
            chk("m_hold_pc2", pc2, h_pc);
            chk("m_hold_instr2", instr2, h_instr);
            chk("m_hold_mis2", mis2, h_mis);
          end else if (valid2) begin
            chk("m_pc2", pc2, exp_pc);
            if (exp_pc[1:0] != 2'b00) begin
              chk("m_exc_mis2", mis2, 1);
              chk("m_exc_instr2", instr2, NOP);
              exc_wait = 1;
            end else begin
              chk("m_mis2", mis2, 0);
              chk("m_instr2", instr2, exp_pc);
              exp_pc = exp_pc + 32'd4;
            end
          end else begin
            chk("m_idle_instr2", instr2, NOP);
            chk("m_idle_mis2", mis2, 0);
          end
          held    = valid2 && stall;
          h_pc    = pc2;
          h_instr = instr2;
          h_mis   = mis2;
          flushed = trap || redirect;
          if (flushed) begin
            exp_pc   = trap ? trap_pc : redirect_pc;
            exc_wait = 0;
            held     = 0;
          end
        end
      end
    end
  end

  initial begin
    nrst        = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    trap        = 1'b0;
    trap_pc     = 32'd0;
    gnt_en      = 1'b1;
    rv_block    = 1'b0;
    #2;
    nrst  = 1'b0;
    armed = 1'b1;
    ne();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST);
    chk("rst_pc2", pc2, 0);
    chk("rst_instr2", instr2, NOP);
    chk("rst_mis2", mis2, 0);
    chk("rst_valid2", valid2, 0);

    // reset stream
    step(); nrst = 1'b1;
    ne(); chk("c0_req", imem_req, 1); chk("c0_addr", imem_addr, 32'h100);
    step();
    ne(); chk("c1_addr", imem_addr, 32'h104);
    step();
    ne(); chk("c2_addr", imem_addr, 32'h108);
    chk("c2_instr2", instr2, 32'h100); chk("c2_valid2", valid2, 1);

    // backpressure: 0x104 held, 0x108 parked in skid
    for (int i = 0; i < 3; i++) begin
      step(); stall = 1'b1;
      ne(); chk("bp_instr2", instr2, 32'h104); chk("bp_req", imem_req, 0);
    end
    step(); stall = 1'b0;
    ne(); chk("bp_rel_req", imem_req, 0); chk("bp_rel_instr2", instr2, 32'h104);
    step();
    ne(); chk("bp_skid_instr2", instr2, 32'h108);
    chk("bp_resume_req", imem_req, 1); chk("bp_resume_addr", imem_addr, 32'h10C);
    step();
    ne(); chk("c8_valid2", valid2, 0);
    step();
    ne(); chk("c9_instr2", instr2, 32'h10C);

    // redirect while a request is outstanding
    step(); rv_block = 1'b1;
    ne(); chk("c10_req", imem_req, 0); chk("c10_instr2", instr2, 32'h110);
    step(); redirect = 1'b1; redirect_pc = 32'h200;
    ne(); chk("c11_req", imem_req, 0);
    step(); redirect = 1'b0; rv_block = 1'b0;
    ne(); chk("drain_valid2", valid2, 0); chk("drain_req", imem_req, 0);
    step();
    ne(); chk("rd_req", imem_req, 1); chk("rd_addr", imem_addr, 32'h200);
    step();
    ne(); chk("rd_addr2", imem_addr, 32'h204);

    // misaligned target, redirect coinciding with rvalid
    step(); redirect = 1'b1; redirect_pc = 32'h302;
    ne(); chk("c15_instr2", instr2, 32'h200); chk("c15_req", imem_req, 0);
    step(); redirect = 1'b0;
    ne(); chk("c16_req", imem_req, 0); chk("c16_valid2", valid2, 0);
    step();
    ne(); chk("exc_pc2", pc2, 32'h302); chk("exc_instr2", instr2, NOP);
    chk("exc_mis2", mis2, 1); chk("exc_valid2", valid2, 1);
    chk("exc_req", imem_req, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      ne(); chk("exc_idle_req", imem_req, 0); chk("exc_idle_valid2", valid2, 0);
    end

    // trap beats redirect
    step(); trap = 1'b1; trap_pc = 32'h80; redirect = 1'b1; redirect_pc = 32'h400;
    ne(); chk("c20_req", imem_req, 0);
    step(); trap = 1'b0; redirect = 1'b0;
    ne(); chk("prio_req", imem_req, 1); chk("prio_addr", imem_addr, 32'h80);
    step();
    ne(); chk("c22_addr", imem_addr, 32'h84);
    step();
    ne(); chk("c23_pc2", pc2, 32'h80); chk("c23_instr2", instr2, 32'h80);

    // wrap around the top of the address space
    step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    ne(); chk("c24_instr2", instr2, 32'h84);
    step(); redirect = 1'b0;
    ne(); chk("w_addr0", imem_addr, 32'hFFFF_FFF8); chk("w_valid2", valid2, 0);
    step();
    ne(); chk("w_addr1", imem_addr, 32'hFFFF_FFFC);
    step();
    ne(); chk("w_addr2", imem_addr, 32'h0); chk("w_req2", imem_req, 1);
    chk("w_instr2", instr2, 32'hFFFF_FFF8);
    step(); rv_block = 1'b1;
    ne(); chk("w_instr2b", instr2, 32'hFFFF_FFFC); chk("w_wait_req", imem_req, 0);

    // reset mid-WAIT, stale response afterwards
    step(); nrst = 1'b0; gnt_en = 1'b0;
    ne(); chk("mr_req", imem_req, 0); chk("mr_addr", imem_addr, RST);
    chk("mr_pc2", pc2, 0); chk("mr_instr2", instr2, NOP);
    chk("mr_mis2", mis2, 0); chk("mr_valid2", valid2, 0);
    step(); nrst = 1'b1; rv_block = 1'b0;
    ne(); chk("mr_rel_req", imem_req, 1); chk("mr_rel_addr", imem_addr, RST);
    chk("mr_stale_seen", imem_rvalid, 1);
    step(); gnt_en = 1'b1;
    ne(); chk("mr_stale_valid2", valid2, 0);
    step();
    ne(); chk("mr_valid2b", valid2, 0); chk("mr_addr2", imem_addr, 32'h104);
    step();
    ne(); chk("mr_instr2", instr2, 32'h100); chk("mr_valid2c", valid2, 1);
    for (int i = 0; i < 4; i++) step();
    ne();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch front end that drives the decode stage's `pc2`/`instr2`/`instruction_addr_misaligned2` inputs. It owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding. It absorbs decode backpressure through a one-entry skid buffer and applies execute-stage redirects and commit-stage traps. Empty slots are presented to decode as the NOP `32'h00000033`.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h0000_0033`: encoding driven on `instr2` when no valid instruction is present.
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `stall` in 1: decode cannot accept; `pc2`/`instr2`/`instruction_addr_misaligned2`/`valid2` must hold.
- `redirect` in 1: taken branch/jump from execute.
- `redirect_pc` in 32: redirect target.
- `trap` in 1: exception/return redirect from commit; has priority over `redirect`.
- `trap_pc` in 32: trap/return target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word aligned whenever `imem_req`=1.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid. Arrives at least one cycle after `gnt`; exactly one response per grant.
- `imem_rdata` in 32: instruction word.
- `pc2` out 32: PC of the presented instruction.
- `instr2` out 32: instruction to decode.
- `instruction_addr_misaligned2` out 1: presented slot carries a misaligned-fetch exception.
- `valid2` out 1: presented slot holds a real instruction or exception.

## Operation
- Internal state:
  - `fetch_pc` (32b).
  - Output register: `pc2`, `instr2`, `misaligned2`, `valid2`.
  - Skid register: pc, instr, valid.
  - FSM states FETCH, WAIT, HOLD, DRAIN, EXC.
- `out_free` = `!valid2 || !stall`.
- **FETCH**
  - If `fetch_pc[1:0]==0`: `imem_req`=1, `imem_addr`=`fetch_pc`. On `gnt`, go to WAIT.
  - If `fetch_pc[1:0]!=0`: `imem_req`=0. When `out_free`, load the output register with `pc2`=`fetch_pc`, `instr2`=NOP, `misaligned2`=1, `valid2`=1, then go to EXC.
- **WAIT**, on `rvalid`:
  - If `out_free`:
    - Load the output register with `{fetch_pc, rdata, 0, 1}`.
    - `fetch_pc` += 4.
    - In the same cycle drive `imem_req`=1, `imem_addr`=`fetch_pc`+4. Go to WAIT if `gnt`, else FETCH.
  - Otherwise: capture into the skid register, `imem_req`=0, go to HOLD.
- **HOLD**: when `!stall`, move the skid register to the output register, clear the skid, `fetch_pc` += 4, go to FETCH.
- **Output drain**: when `!stall` and no new slot is loaded, the output register is cleared (`valid2`=0, `instr2`=NOP, `misaligned2`=0). `pc2` holds its last value.
- **EXC**: no requests. Leave only on `trap` or `redirect`.
- **Redirect/trap**, any state:
  - New PC = `trap ? trap_pc : redirect_pc`, loaded into `fetch_pc`.
  - Output register and skid are cleared, regardless of `stall`.
  - Next state is DRAIN if a request is outstanding (state WAIT, or FETCH/WAIT-accept cycle with `gnt`=1 this cycle); otherwise FETCH.
  - No `imem_req` is issued in the redirect cycle.
- **DRAIN**: `imem_req`=0. On `rvalid`, drop the data and go to FETCH. A new redirect/trap in DRAIN only updates `fetch_pc`.
- PC arithmetic is modulo 2^32; `32'hFFFF_FFFC`+4 wraps to `0`.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `pc2`=0, `instr2`=NOP, `instruction_addr_misaligned2`=0, `valid2`=0.
  - `fetch_pc`=`RESET_PC`, skid empty, state FETCH.
- First cycle after `nrst` deasserts: `imem_req`=1.
- Latency: request in cycle N with `gnt`, `rvalid` in N+1 → `instr2` valid from N+2.
- Throughput: with a 1-cycle memory and no stall, one instruction per cycle.
- Outputs change only on `clk` edges. While `stall`=1 and `valid2`=1, the outputs are bit-stable.
- Redirect/trap in cycle N: the output is NOP/`valid2`=0 from N+1. The first request to the new PC is at N+1 if nothing is outstanding, else the cycle after the stale `rvalid`.
- Simultaneous `rvalid` and redirect: the response is dropped and the state goes to FETCH.
- Simultaneous `trap` and `redirect`: `trap_pc` wins.
- Reset mid-operation: immediate return to reset values. A stale `rvalid` arriving after reset in state FETCH is ignored.

## Test plan
- **Reset stream**: 1-cycle memory returning `instr=addr`, `RESET_PC`=`0x100`, no stall.
  - `imem_addr` = `0x100`, `0x104`, `0x108`… on consecutive cycles.
  - `instr2`=`0x100` two cycles after reset release, then one instruction per cycle.
- **Backpressure**: hold `stall`=1 for 3 cycles while 0x104 is presented.
  - `instr2` stays `0x104`.
  - `0x108` sits in skid, state HOLD, no `imem_req`.
  - After release, `0x108` is presented next cycle and fetching resumes at `0x10C`.
- **Redirect while outstanding**: `redirect`=1, `redirect_pc`=`0x200`, in the WAIT cycle before `rvalid`.
  - The stale response is dropped; `valid2`=0 next cycle.
  - The next `imem_addr` is `0x200`; no stale instruction ever has `valid2`=1.
- **Misaligned target**: `redirect_pc`=`0x302`.
  - No `imem_req` to `0x302`.
  - `pc2`=`0x302`, `instr2`=`0x33`, `misaligned2`=1, `valid2`=1.
  - Stays idle until `trap` with `trap_pc`=`0x80`, then fetches `0x80`.
- **Priority**: `trap` (`0x80`) and `redirect` (`0x400`) in the same cycle → next fetch at `0x80`.
- **Wrap and reset**:
  - Stream from `0xFFFF_FFF8` → addresses `0xFFFF_FFFC`, then `0x0`.
  - Assert `nrst`=0 mid-WAIT → all outputs at reset values immediately; the late `rvalid` is ignored.
